// File: rtl/sap_ram_addr_ctrl.sv
// SAP-1 RAM address mux owner: arbitrates the 16-word RAM between the CPU (MAR, mux B)
// and the program loader (mux A), with halt/drain and guard cycles at each handover.
module sap_ram_addr_ctrl #(
  parameter int unsigned AW    = 4,
  parameter int unsigned GUARD = 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          prog_mode,
  input  logic          cpu_req,
  output logic          cpu_gnt,
  output logic          cpu_halt,
  input  logic          ldr_req,
  input  logic          ldr_we,
  output logic          ldr_gnt,
  output logic          ram_we,
  output logic          mux_sel,
  output logic [AW:0]   ldr_count
);

  localparam int unsigned CW        = AW + 1;
  localparam int unsigned GW        = 3;
  localparam logic [AW:0] CNT_MAX   = CW'(1) << AW;
  localparam logic [2:0]  GUARD_LD  = (GUARD == 0) ? 3'd0 : GW'(GUARD - 1);
  localparam logic        HAS_GUARD = (GUARD != 0);

  typedef enum logic [2:0] {
    S_CPU     = 3'd0,
    S_DRAIN   = 3'd1,
    S_GUARD_L = 3'd2,
    S_LOADER  = 3'd3,
    S_GUARD_C = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  gcnt_q, gcnt_d;
  logic [AW:0] ldr_count_q, ldr_count_d;
  logic        mux_sel_q, mux_sel_d;
  logic        cpu_halt_q, cpu_halt_d;

  // State and registered decodes
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_CPU;
      gcnt_q      <= 3'd0;
      ldr_count_q <= '0;
      mux_sel_q   <= 1'b0;
      cpu_halt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      ldr_count_q <= ldr_count_d;
      mux_sel_q   <= mux_sel_d;
      cpu_halt_q  <= cpu_halt_d;
    end
  end

  // Next-state: an abandoned drain returns to CPU, an active loader access is never cut
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CPU: begin
        if (prog_mode) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!prog_mode)    state_d = S_CPU;
        else if (!cpu_req) state_d = HAS_GUARD ? S_GUARD_L : S_LOADER;
      end
      S_GUARD_L: begin
        if (gcnt_q == 3'd0) state_d = S_LOADER;
      end
      S_LOADER: begin
        if (!prog_mode && !ldr_req) state_d = HAS_GUARD ? S_GUARD_C : S_CPU;
      end
      S_GUARD_C: begin
        if (gcnt_q == 3'd0) state_d = S_CPU;
      end
      default: state_d = S_CPU;
    endcase
  end

  // Outputs: grants are combinational and gated by reset; mux/halt follow the next state
  always_comb begin
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    ram_we     = 1'b0;
    mux_sel_d  = 1'b0;
    cpu_halt_d = 1'b1;
    if (clr_n) begin
      cpu_gnt = cpu_req & ((state_q == S_CPU) | (state_q == S_DRAIN));
      ldr_gnt = ldr_req & (state_q == S_LOADER);
      ram_we  = ldr_gnt & ldr_we;
    end
    mux_sel_d  = (state_d == S_GUARD_L) | (state_d == S_LOADER);
    cpu_halt_d = (state_d != S_CPU);
  end

  // Guard down-counter and saturating loader write counter
  always_comb begin
    gcnt_d      = gcnt_q;
    ldr_count_d = ldr_count_q;
    if ((state_d != state_q) &&
        ((state_d == S_GUARD_L) || (state_d == S_GUARD_C))) begin
      gcnt_d = GUARD_LD;
    end else if (((state_q == S_GUARD_L) || (state_q == S_GUARD_C)) &&
                 (gcnt_q != 3'd0)) begin
      gcnt_d = gcnt_q - 3'd1;
    end
    if ((state_d == S_LOADER) && (state_q != S_LOADER)) begin
      ldr_count_d = '0;
    end else if (ram_we && (ldr_count_q != CNT_MAX)) begin
      ldr_count_d = ldr_count_q + CW'(1);
    end
  end

  assign mux_sel   = mux_sel_q;
  assign cpu_halt  = cpu_halt_q;
  assign ldr_count = ldr_count_q;

endmodule

// File: tb/tb_sap_ram_addr_ctrl.sv
// Directed bench for sap_ram_addr_ctrl (AW=4, GUARD=1).
module tb_sap_ram_addr_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       prog_mode, cpu_req, ldr_req, ldr_we;
  logic       cpu_gnt, cpu_halt, ldr_gnt, ram_we, mux_sel;
  logic [4:0] ldr_count;

  int checks = 0;
  int errors = 0;

  sap_ram_addr_ctrl #(.AW(4), .GUARD(1)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .prog_mode (prog_mode),
    .cpu_req   (cpu_req),
    .cpu_gnt   (cpu_gnt),
    .cpu_halt  (cpu_halt),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_gnt   (ldr_gnt),
    .ram_we    (ram_we),
    .mux_sel   (mux_sel),
    .ldr_count (ldr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares packed outputs {mux_sel,cpu_halt,cpu_gnt,ldr_gnt,ram_we} against expectation
  task automatic test_reset();
    clr_n = 1'b0; prog_mode = 1'b0; cpu_req = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1;
    #12;
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_gnt, ram_we} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=00000", {mux_sel, cpu_halt, cpu_gnt, ldr_gnt, ram_we});
    end
    checks++;
    if (ldr_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", ldr_count);
    end
    clr_n = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
    step();
    cpu_req = 1'b1; #1;
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_gnt} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_cpu_state got=%b exp=0010", {mux_sel, cpu_halt, cpu_gnt, ldr_gnt});
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_handover();
    prog_mode = 1'b1; cpu_req = 1'b1;
    step();  // edge 1: DRAIN
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt} !== 3'b011) begin
      errors++;
      $display("FAIL ho_drain got=%b exp=011", {mux_sel, cpu_halt, cpu_gnt});
    end
    step();  // edge 2: still DRAIN, CPU access ends
    cpu_req = 1'b0;
    ldr_req = 1'b1; #1;
    checks++;
    if ({mux_sel, cpu_halt, ldr_gnt} !== 3'b010) begin
      errors++;
      $display("FAIL ho_drain2 got=%b exp=010", {mux_sel, cpu_halt, ldr_gnt});
    end
    step();  // edge 3: GUARD_L
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_gnt} !== 4'b1100) begin
      errors++;
      $display("FAIL ho_guard got=%b exp=1100", {mux_sel, cpu_halt, cpu_gnt, ldr_gnt});
    end
    step();  // edge 4: LOADER
    checks++;
    if ({mux_sel, cpu_halt, ldr_gnt, ram_we} !== 4'b1110) begin
      errors++;
      $display("FAIL ho_loader got=%b exp=1110", {mux_sel, cpu_halt, ldr_gnt, ram_we});
    end
    ldr_req = 1'b0;
  endtask

  task automatic test_load();
    logic [6:0] pat;
    int pulses;
    pat = 7'b1101101;  // 5 writes, 2 reads
    pulses = 0;
    cpu_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ldr_req = 1'b1; ldr_we = pat[i]; #1;
      if (ram_we === 1'b1) pulses++;
      checks++;
      if (cpu_gnt !== 1'b0) begin
        errors++;
        $display("FAIL load_cpu_gnt cycle=%0d got=%b exp=0", i, cpu_gnt);
      end
      step();
    end
    ldr_req = 1'b0; ldr_we = 1'b0; cpu_req = 1'b0; #1;
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL load_pulses got=%0d exp=5", pulses);
    end
    checks++;
    if (ldr_count !== 5'd5) begin
      errors++;
      $display("FAIL load_count got=%0d exp=5", ldr_count);
    end
  endtask

  task automatic test_saturation();
    ldr_req = 1'b1; ldr_we = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (ldr_count !== 5'd16) begin
      errors++;
      $display("FAIL sat_count got=%0d exp=16", ldr_count);
    end
    step(); step();
    checks++;
    if (ldr_count !== 5'd16) begin
      errors++;
      $display("FAIL sat_hold got=%0d exp=16", ldr_count);
    end
    ldr_we = 1'b0;
  endtask

  task automatic test_return();
    prog_mode = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({mux_sel, cpu_halt, ldr_gnt} !== 3'b111) begin
        errors++;
        $display("FAIL ret_hold cycle=%0d got=%b exp=111", i, {mux_sel, cpu_halt, ldr_gnt});
      end
      step();
    end
    ldr_req = 1'b0;
    step();  // GUARD_C
    cpu_req = 1'b1; ldr_req = 1'b1; prog_mode = 1'b1; #1;
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_gnt} !== 4'b0100) begin
      errors++;
      $display("FAIL ret_guard got=%b exp=0100", {mux_sel, cpu_halt, cpu_gnt, ldr_gnt});
    end
    prog_mode = 1'b0;
    step();  // CPU
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_gnt} !== 4'b0010) begin
      errors++;
      $display("FAIL ret_cpu got=%b exp=0010", {mux_sel, cpu_halt, cpu_gnt, ldr_gnt});
    end
    checks++;
    if (ldr_count !== 5'd16) begin
      errors++;
      $display("FAIL ret_count_hold got=%0d exp=16", ldr_count);
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
  endtask

  task automatic test_abort_drain();
    cpu_req = 1'b1; prog_mode = 1'b1;
    step();  // DRAIN
    prog_mode = 1'b0; ldr_req = 1'b1; #1;
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_gnt} !== 4'b0110) begin
      errors++;
      $display("FAIL abort_drain got=%b exp=0110", {mux_sel, cpu_halt, cpu_gnt, ldr_gnt});
    end
    step();  // back to CPU
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_gnt} !== 4'b0010) begin
      errors++;
      $display("FAIL abort_cpu got=%b exp=0010", {mux_sel, cpu_halt, cpu_gnt, ldr_gnt});
    end
    step();
    checks++;
    if ({mux_sel, cpu_halt, ldr_gnt} !== 3'b000) begin
      errors++;
      $display("FAIL abort_stay got=%b exp=000", {mux_sel, cpu_halt, ldr_gnt});
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
  endtask

  task automatic test_reset_mid_loader();
    prog_mode = 1'b1; cpu_req = 1'b0;
    step(); step(); step();  // DRAIN, GUARD_L, LOADER
    ldr_req = 1'b1; ldr_we = 1'b1; #1;
    checks++;
    if ({mux_sel, ram_we} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre got=%b exp=11", {mux_sel, ram_we});
    end
    step();
    checks++;
    if (ldr_count !== 5'd1) begin
      errors++;
      $display("FAIL rst_pre_count got=%0d exp=1", ldr_count);
    end
    #1 clr_n = 1'b0; #1;
    checks++;
    if ({mux_sel, cpu_halt, ram_we, ldr_gnt} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async got=%b exp=0000", {mux_sel, cpu_halt, ram_we, ldr_gnt});
    end
    prog_mode = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
    step();
    clr_n = 1'b1;
    step();
    cpu_req = 1'b1; #1;
    checks++;
    if ({mux_sel, cpu_halt, cpu_gnt, ldr_count} !== {3'b001, 5'd0}) begin
      errors++;
      $display("FAIL rst_after got=%b exp=00100000", {mux_sel, cpu_halt, cpu_gnt, ldr_count});
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_handover();
    test_load();
    test_saturation();
    test_return();
    test_abort_drain();
    test_reset_mid_loader();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
